// File: rtl/enc_pkg.sv
// Shared constants, output FSM state type and popcount helper for the
// pending request encoder.
package enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } out_state_e;

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/lowest_set_pick.sv
// Combinational finder for the lowest set bit of a vector: reports whether
// any bit is set, its binary index and its one-hot.
module lowest_set_pick
  import enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic         found_o,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] onehot_o
);

  assign found_o = |vec_i;

  // Scan downwards so the last hit written is the lowest index.
  always_comb begin
    idx_o    = '0;
    onehot_o = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (vec_i[i-1]) begin
        idx_o         = W'(i - 1);
        onehot_o      = '0;
        onehot_o[i-1] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pending_request_encoder.sv
// Registered request encoder: sticky pending bits, fixed or round-robin
// selection, valid/ready presentation of index and one-hot.
module pending_request_encoder
  import enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = MODE_FIXED
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic [N-1:0] pending,
  output logic [W:0]   pend_count,
  output logic         overflow
);

  out_state_e   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] oh_q, oh_d;
  logic         ovf_q, ovf_d;

  logic         accept;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic         sel_found;
  logic [W-1:0] sel_idx;
  logic [N-1:0] sel_oh;

  assign accept = (state_q == ST_HOLD) && out_ready;
  assign clr    = accept ? oh_q : '0;
  // The presented bit stays in pend_q until accepted, so cand excludes it
  // only in the accept cycle; same-cycle req_in is deliberately not in cand.
  assign cand   = pend_q & ~clr;
  assign pend_d = cand | req_in;
  assign ovf_d  = |(req_in & cand);

  if (MODE == MODE_RR) begin : g_rr
    logic [W-1:0] ptr_q;
    logic         ptr_vld_q;
    logic [W-1:0] eff_ptr;
    logic         eff_vld;
    logic [N-1:0] hi_mask;
    logic [N-1:0] masked;
    logic         m_found, u_found;
    logic [W-1:0] m_idx, u_idx;
    logic [N-1:0] m_oh, u_oh;

    // The index being accepted counts as the pointer for the selection
    // made in the same cycle; before any grant every index is eligible.
    assign eff_ptr = accept ? idx_q : ptr_q;
    assign eff_vld = accept || ptr_vld_q;

    always_comb begin
      hi_mask = '0;
      for (int unsigned i = 0; i < N; i++) begin
        hi_mask[i] = !eff_vld || (i > 32'(eff_ptr));
      end
    end

    assign masked = cand & hi_mask;

    lowest_set_pick #(.N(N), .W(W)) u_pick_masked (
      .vec_i    (masked),
      .found_o  (m_found),
      .idx_o    (m_idx),
      .onehot_o (m_oh)
    );

    lowest_set_pick #(.N(N), .W(W)) u_pick_all (
      .vec_i    (cand),
      .found_o  (u_found),
      .idx_o    (u_idx),
      .onehot_o (u_oh)
    );

    assign sel_found = u_found;
    assign sel_idx   = m_found ? m_idx : u_idx;
    assign sel_oh    = m_found ? m_oh  : u_oh;

    always_ff @(posedge clk) begin
      if (rst) begin
        ptr_q     <= '0;
        ptr_vld_q <= 1'b0;
      end else if (accept) begin
        ptr_q     <= idx_q;
        ptr_vld_q <= 1'b1;
      end
    end
  end else begin : g_fixed
    lowest_set_pick #(.N(N), .W(W)) u_pick (
      .vec_i    (cand),
      .found_o  (sel_found),
      .idx_o    (sel_idx),
      .onehot_o (sel_oh)
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d = ST_HOLD;
          idx_d   = sel_idx;
          oh_d    = sel_oh;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          if (sel_found) begin
            idx_d = sel_idx;
            oh_d  = sel_oh;
          end else begin
            state_d = ST_IDLE;
            oh_d    = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      oh_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid  = (state_q == ST_HOLD);
  assign out_idx    = idx_q;
  assign out_onehot = oh_q;
  assign pending    = pend_q;
  assign overflow   = ovf_q;
  assign pend_count = (W+1)'(popcount(64'(pend_q)));

endmodule

// File: tb/tb_pending_request_encoder.sv
// Scoreboard bench: fixed-priority and round-robin instances driven in
// parallel, expectations from a per-cycle behavioural model.
module tb_pending_request_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_in = '0;
  logic       out_ready = 1'b0;

  logic [1:0] o_valid;
  logic [2:0] o_idx [2];
  logic [7:0] o_oh [2];
  logic [7:0] o_pend [2];
  logic [3:0] o_cnt [2];
  logic [1:0] o_ovf;

  always #5 clk = ~clk;

  pending_request_encoder #(.N(8), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .req_in(req_in), .out_valid(o_valid[0]),
    .out_ready(out_ready), .out_idx(o_idx[0]), .out_onehot(o_oh[0]),
    .pending(o_pend[0]), .pend_count(o_cnt[0]), .overflow(o_ovf[0])
  );

  pending_request_encoder #(.N(8), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .req_in(req_in), .out_valid(o_valid[1]),
    .out_ready(out_ready), .out_idx(o_idx[1]), .out_onehot(o_oh[1]),
    .pending(o_pend[1]), .pend_count(o_cnt[1]), .overflow(o_ovf[1])
  );

  typedef struct {
    bit         valid [2];
    int         idx   [2];
    logic [7:0] pend  [2];
    bit         ovf   [2];
    int         cnt   [2];
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Model state: m=0 fixed priority, m=1 round-robin.
  logic [7:0] m_pend [2];
  bit         m_valid [2];
  int         m_idx [2];
  int         m_last [2];
  bit         m_ovf [2];

  function automatic int pick(input int m, input logic [7:0] c);
    if (m == 0) begin
      for (int i = 0; i < 8; i++) if (c[i]) return i;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        int i;
        i = (m_last[m] + k) % 8;
        if (c[i]) return i;
      end
    end
    return -1;
  endfunction

  task automatic model_step(input int m, input bit r, input logic [7:0] q, input bit rd);
    bit acc;
    logic [7:0] clr, cand;
    if (r) begin
      m_pend[m] = '0; m_valid[m] = 0; m_idx[m] = 0; m_ovf[m] = 0; m_last[m] = 7;
    end else begin
      acc  = m_valid[m] && rd;
      clr  = acc ? (8'd1 << m_idx[m]) : 8'd0;
      cand = m_pend[m] & ~clr;
      m_ovf[m] = |(q & cand);
      if (acc) m_last[m] = m_idx[m];
      if (!m_valid[m] || acc) begin
        if (cand != 0) begin
          m_idx[m] = pick(m, cand);
          m_valid[m] = 1;
        end else begin
          m_valid[m] = 0;
        end
      end
      m_pend[m] = cand | q;
    end
  endtask

  task automatic step(input bit r, input logic [7:0] q, input bit rd);
    exp_t e;
    @(negedge clk);
    rst = r; req_in = q; out_ready = rd;
    for (int m = 0; m < 2; m++) begin
      model_step(m, r, q, rd);
      e.valid[m] = m_valid[m];
      e.idx[m]   = m_idx[m];
      e.pend[m]  = m_pend[m];
      e.ovf[m]   = m_ovf[m];
      e.cnt[m]   = $countones(m_pend[m]);
    end
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int m, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s (mode %0d) at %0t: got %0d, expected %0d", name, m, $time, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int m = 0; m < 2; m++) begin
          chk("out_valid", m, int'(o_valid[m]), int'(e.valid[m]));
          chk("pending", m, int'(o_pend[m]), int'(e.pend[m]));
          chk("pend_count", m, int'(o_cnt[m]), e.cnt[m]);
          chk("overflow", m, int'(o_ovf[m]), int'(e.ovf[m]));
          if (e.valid[m]) begin
            chk("out_idx", m, int'(o_idx[m]), e.idx[m]);
            chk("out_onehot", m, int'(o_oh[m]), 1 << e.idx[m]);
          end else begin
            chk("out_onehot_idle", m, int'(o_oh[m]), 0);
          end
        end
      end
    end
  end

  initial begin : driver
    // Reset with all requests asserted; nothing may be captured.
    step(1, 8'hFF, 1); step(1, 8'hFF, 1);
    // Single request, presentation two cycles later.
    step(0, 8'h08, 1);
    repeat (4) step(0, 8'h00, 1);
    // Three simultaneous requests drained back to back.
    step(0, 8'hA4, 1);
    repeat (5) step(0, 8'h00, 1);
    // Hold under back-pressure, then release.
    step(0, 8'h81, 0);
    repeat (5) step(0, 8'h00, 0);
    repeat (4) step(0, 8'h00, 1);
    // Sustained all-ones requests.
    repeat (12) step(0, 8'hFF, 1);
    repeat (10) step(0, 8'h00, 1);
    // Overflow on an unaccepted bit, none on the bit being accepted.
    step(0, 8'h08, 0); step(0, 8'h00, 0); step(0, 8'h08, 0);
    step(0, 8'h00, 0); step(0, 8'h08, 1);
    repeat (4) step(0, 8'h00, 1);
    // Reset while presenting.
    step(0, 8'h30, 0); step(0, 8'h00, 0); step(0, 8'h00, 0);
    step(1, 8'h00, 0); step(0, 8'h00, 1); step(0, 8'h00, 1);
    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] q;
      bit rd, r;
      q  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      rd = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 80) == 0);
      step(r, q, rd);
    end
    repeat (12) step(0, 8'h00, 1);
    @(posedge clk);
    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
